// File: rtl/fb_vga_out.sv
// 640x480 VGA timing generator that scans a half-resolution RGB565 frame buffer with 2x2 upscaling.
// Optional FB_VGA_TESTPAT_EN adds a tp_en input selecting an 8-bar colour test pattern.
module fb_vga_out #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned FB_W     = 320
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FB_VGA_TESTPAT_EN
    input  logic        tp_en,
`endif
    output logic [16:0] raddr,
    input  logic [15:0] rdata,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned A_W      = 17;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Control bundle {de, hsync_n, vsync_n, frame_start}; idle value has syncs high.
    localparam logic [3:0] CTL_IDLE = 4'b0110;

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic [A_W-1:0] r_line_base;
    logic [A_W-1:0] r_raddr;
    logic [3:0]     r_ctl_d1;
    logic [3:0]     r_ctl_d2;
    logic [3:0]     r_ctl_d3;
    logic [4:0]     r_red;
    logic [5:0]     r_green;
    logic [4:0]     r_blue;

    logic           w_h_last;
    logic           w_v_last;
    logic           w_h_vis;
    logic           w_v_vis;
    logic           w_vis;
    logic           w_hs_n;
    logic           w_vs_n;
    logic           w_fs;
    logic [3:0]     w_ctl;
    logic [15:0]    w_pix;

    assign w_h_last = (r_h_cnt == H_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == V_W'(V_TOTAL - 1));
    assign w_h_vis  = (r_h_cnt <  H_W'(H_ACTIVE));
    assign w_v_vis  = (r_v_cnt <  V_W'(V_ACTIVE));
    assign w_vis    = w_h_vis && w_v_vis;
    assign w_hs_n   = !((r_h_cnt >= H_W'(HS_START)) && (r_h_cnt < H_W'(HS_END)));
    assign w_vs_n   = !((r_v_cnt >= V_W'(VS_START)) && (r_v_cnt < V_W'(VS_END)));
    assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_ctl    = {w_vis, w_hs_n, w_vs_n, w_fs};

    // Raster position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_W'(1);
        end
    end

    // Buffer row start: steps one buffer line every two display lines, zero in vertical blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_base <= '0;
        end else if (w_h_last) begin
            if (w_v_last || (r_v_cnt == V_W'(V_ACTIVE - 1))) begin
                r_line_base <= '0;
            end else if (w_v_vis && r_v_cnt[0]) begin
                r_line_base <= r_line_base + A_W'(FB_W);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr <= '0;
        end else if (w_vis) begin
            r_raddr <= r_line_base + A_W'(r_h_cnt >> 1);
        end else if (w_v_vis) begin
            r_raddr <= r_line_base;
        end else begin
            r_raddr <= '0;
        end
    end

    // Three-stage control delay matching raddr -> rdata -> colour latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl_d1 <= CTL_IDLE;
            r_ctl_d2 <= CTL_IDLE;
            r_ctl_d3 <= CTL_IDLE;
        end else begin
            r_ctl_d1 <= w_ctl;
            r_ctl_d2 <= r_ctl_d1;
            r_ctl_d3 <= r_ctl_d2;
        end
    end

`ifdef FB_VGA_TESTPAT_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0]  r_bar_d1;
    logic [2:0]  r_bar_d2;
    logic [15:0] w_tp_rgb;

    // Bar index travels with the read pipeline so the pattern lines up with buffer pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bar_d1 <= '0;
            r_bar_d2 <= '0;
        end else begin
            r_bar_d1 <= 3'(r_h_cnt / H_W'(BAR_W));
            r_bar_d2 <= r_bar_d1;
        end
    end

    // Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    assign w_tp_rgb = {{5{~r_bar_d2[1]}}, {6{~r_bar_d2[2]}}, {5{~r_bar_d2[0]}}};
`endif

    always_comb begin
        w_pix = rdata;
`ifdef FB_VGA_TESTPAT_EN
        if (tp_en) begin
            w_pix = w_tp_rgb;
        end
`endif
    end

    // Colour stage: blank to black whenever the aligned de is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (r_ctl_d2[3]) begin
            r_red   <= w_pix[15:11];
            r_green <= w_pix[10:5];
            r_blue  <= w_pix[4:0];
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign raddr       = r_raddr;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign de          = r_ctl_d3[3];
    assign hsync       = r_ctl_d3[2];
    assign vsync       = r_ctl_d3[1];
    assign frame_start = r_ctl_d3[0];

endmodule

// File: tb/tb_fb_vga_out.sv
// Directed bench for fb_vga_out on a reduced raster (48x15 total, 32x8 visible, 16-wide buffer).
// RAM returns its own address as data; every cycle is also compared against a position model.
module tb_fb_vga_out;

    localparam int TH_A   = 32;
    localparam int TH_FP  = 4;
    localparam int TH_S   = 6;
    localparam int TH_BP  = 6;
    localparam int TV_A   = 8;
    localparam int TV_FP  = 2;
    localparam int TV_S   = 2;
    localparam int TV_BP  = 3;
    localparam int TFB    = 16;
    localparam int TH_TOT = TH_A + TH_FP + TH_S + TH_BP;
    localparam int TV_TOT = TV_A + TV_FP + TV_S + TV_BP;
    localparam int FRAME  = TH_TOT * TV_TOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] raddr;
    logic [15:0] rdata;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
    logic        tp_sel;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    always #5 clk = ~clk;

    fb_vga_out #(
        .H_ACTIVE(TH_A), .H_FP(TH_FP), .H_SYNC(TH_S), .H_BP(TH_BP),
        .V_ACTIVE(TV_A), .V_FP(TV_FP), .V_SYNC(TV_S), .V_BP(TV_BP),
        .FB_W(TFB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FB_VGA_TESTPAT_EN
        .tp_en      (tp_sel),
`endif
        .raddr      (raddr),
        .rdata      (rdata),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_start(frame_start)
    );

    // Synchronous RAM whose content equals its address.
    always_ff @(posedge clk) rdata <= raddr[15:0];

    typedef struct {
        int          cyc;
        logic [19:0] exp;
        string       name;
    } vec_t;

    function automatic logic [19:0] mk(input logic d, input logic hs, input logic vs,
                                       input logic fs, input logic [15:0] col);
        return {d, hs, vs, fs, col};
    endfunction

    function automatic logic [15:0] bar_col(input int h);
        int idx;
        idx = h / (TH_A / 8);
        case (idx)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Expected outputs in cycle kk after reset release (outputs trail the raster by 3 clks).
    function automatic logic [19:0] exp_out(input int kk, input logic tp);
        int p, h, v;
        logic d, hs, vs, fs;
        logic [15:0] col;
        p = kk - 3;
        if (p < 0) return mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        h  = p % TH_TOT;
        v  = (p / TH_TOT) % TV_TOT;
        d  = (h < TH_A) && (v < TV_A);
        hs = !((h >= TH_A + TH_FP) && (h < TH_A + TH_FP + TH_S));
        vs = !((v >= TV_A + TV_FP) && (v < TV_A + TV_FP + TV_S));
        fs = (h == 0) && (v == 0);
        col = 16'h0;
        if (d) col = tp ? bar_col(h) : 16'((v / 2) * TFB + h / 2);
        return mk(d, hs, vs, fs, col);
    endfunction

    function automatic logic [19:0] exp_addr(input int kk);
        int p, h, v;
        if (kk == 0) return 20'h0;
        p = kk - 1;
        h = p % TH_TOT;
        v = (p / TH_TOT) % TV_TOT;
        if (v >= TV_A) return 20'h0;
        if (h < TH_A) return 20'((v / 2) * TFB + h / 2);
        return 20'((v / 2) * TFB);
    endfunction

    function automatic logic [19:0] act_vec();
        return {de, hsync, vsync, frame_start, red, green, blue};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    task automatic stream_check();
        check("stream_out", act_vec(), exp_out(k, tp_sel));
        check("stream_addr", {3'b0, raddr}, exp_addr(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        stream_check();
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{0,   mk(0, 1, 1, 0, 16'd0),  "rst_release"};
        tbl[1]  = '{2,   mk(0, 1, 1, 0, 16'd0),  "pipe_clear"};
        tbl[2]  = '{3,   mk(1, 1, 1, 1, 16'd0),  "first_pix"};
        tbl[3]  = '{4,   mk(1, 1, 1, 0, 16'd0),  "pix1_dup"};
        tbl[4]  = '{5,   mk(1, 1, 1, 0, 16'd1),  "pix2"};
        tbl[5]  = '{34,  mk(1, 1, 1, 0, 16'd15), "line0_end"};
        tbl[6]  = '{35,  mk(0, 1, 1, 0, 16'd0),  "de_fall"};
        tbl[7]  = '{39,  mk(0, 0, 1, 0, 16'd0),  "hs_start"};
        tbl[8]  = '{44,  mk(0, 0, 1, 0, 16'd0),  "hs_last"};
        tbl[9]  = '{45,  mk(0, 1, 1, 0, 16'd0),  "hs_end"};
        tbl[10] = '{51,  mk(1, 1, 1, 0, 16'd0),  "line1_repeat"};
        tbl[11] = '{99,  mk(1, 1, 1, 0, 16'd16), "line2_start"};
        tbl[12] = '{152, mk(1, 1, 1, 0, 16'd18), "line3_pix5"};
        tbl[13] = '{370, mk(1, 1, 1, 0, 16'd63), "last_pix"};
        tbl[14] = '{371, mk(0, 1, 1, 0, 16'd0),  "after_last"};
        tbl[15] = '{482, mk(0, 1, 1, 0, 16'd0),  "vs_before"};
        tbl[16] = '{483, mk(0, 1, 0, 0, 16'd0),  "vs_start"};
        tbl[17] = '{578, mk(0, 1, 0, 0, 16'd0),  "vs_last"};
        tbl[18] = '{579, mk(0, 1, 1, 0, 16'd0),  "vs_end"};
        tbl[19] = '{723, mk(1, 1, 1, 1, 16'd0),  "frame2_start"};

        rst    = 1'b1;
        tp_sel = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_out", act_vec(), mk(0, 1, 1, 0, 16'd0));
        check("reset_addr", {3'b0, raddr}, 20'h0);

        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        stream_check();

        for (int i = 0; i < 20; i++) begin
            run_to(tbl[i].cyc);
            check(tbl[i].name, act_vec(), tbl[i].exp);
        end

        run_to(2 * FRAME + 60);

        // Reset in the middle of a visible line of the third frame.
        run_to(2 * FRAME + 5 * TH_TOT + 10);
        check("pre_rst_de", {19'h0, de}, 20'h1);
        rst = 1'b1;
        #1;
        check("rst_async_out", act_vec(), mk(0, 1, 1, 0, 16'd0));
        check("rst_async_addr", {3'b0, raddr}, 20'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_out", act_vec(), mk(0, 1, 1, 0, 16'd0));
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        stream_check();
        run_to(1);
        check("post_rst_addr", {3'b0, raddr}, 20'h0);
        run_to(2);
        check("post_rst_no_fs", {19'h0, frame_start}, 20'h0);
        run_to(3);
        check("post_rst_fs", act_vec(), mk(1, 1, 1, 1, 16'd0));
        run_to(FRAME + 10);

`ifdef FB_VGA_TESTPAT_EN
        // Switch to the pattern during vertical blanking, then sample bars of the next frame.
        run_to(2 * FRAME - 100);
        tp_sel = 1'b1;
        run_to(2 * FRAME + 3);
        check("tp_white", act_vec(), mk(1, 1, 1, 1, 16'hFFFF));
        run_to(2 * FRAME + 3 + 4);
        check("tp_yellow", act_vec(), mk(1, 1, 1, 0, 16'hFFE0));
        run_to(2 * FRAME + 3 + 16);
        check("tp_magenta", act_vec(), mk(1, 1, 1, 0, 16'hF81F));
        run_to(2 * FRAME + 3 + 28);
        check("tp_black", act_vec(), mk(1, 1, 1, 0, 16'h0000));
        run_to(3 * FRAME - 100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_vga_out.md
FB_VGA_OUT -- requirements
Module: fb_vga_out

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync width and back porch in clocks.
REQ-003 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical front porch, sync width and back porch in lines.
REQ-005 SHALL have parameter FB_W, 320, frame-buffer pixels per line; the buffer holds FB_W x V_ACTIVE/2 pixels, 76800 by default.
REQ-006 SHALL have port clk, input, 1, 25 MHz pixel clock; single clock domain.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port raddr, output, 17, frame-buffer read address.
REQ-009 SHALL have port rdata, input, 16, RGB565 read data, valid one clk after raddr.
REQ-010 SHALL have ports red, output, 5; green, output, 6; blue, output, 5: pixel colour.
REQ-011 SHALL have ports hsync and vsync, output, 1 each: active-low syncs.
REQ-012 SHALL have port de, output, 1: high during visible pixels.
REQ-013 SHALL have port frame_start, output, 1: one-clk pulse marking the first visible pixel of a frame.

Function
REQ-014 SHALL count h_cnt 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); h_cnt wraps to 0 and advances v_cnt.
REQ-015 SHALL count v_cnt 0..V_TOTAL-1 (525) and wrap to 0 after the last clk of line V_TOTAL-1.
REQ-016 SHALL treat the region h_cnt<H_ACTIVE and v_cnt<V_ACTIVE as visible; syncs are low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and for v_cnt in the equivalent vertical range.
REQ-017 SHALL upscale 2x2: pixel (x,y) reads address (y>>1)*FB_W + (x>>1); each buffer word is shown on 2 clks and 2 lines.
REQ-018 SHALL compute the address without a multiplier: a line_base register advances by FB_W after every odd visible line and clears to 0 when v_cnt wraps.
REQ-019 SHALL register raddr from the counter state: counters at cycle n give raddr at n+1, rdata at n+2, and red/green/blue at n+3.
REQ-020 SHALL delay hsync, vsync, de and frame_start by 3 clks so they stay aligned with colour.
REQ-021 SHALL hold raddr at line_base outside visible pixels, which prefetches the next line start; raddr is 0 throughout vertical blanking.
REQ-022 SHALL drive red/green/blue with rdata[15:11], rdata[10:5], rdata[4:0] when delayed de=1, and with 0 when delayed de=0.
REQ-023 SHALL never let raddr exceed FB_W*V_ACTIVE/2-1 (76799); the final visible pixel reads 76799.
REQ-024 SHALL assert frame_start for one clk only, aligned with the first visible pixel (h_cnt=0, v_cnt=0 plus 3 clks of delay).

Reset
REQ-025 SHALL clear h_cnt, v_cnt, line_base and raddr to 0 on rst.
REQ-026 SHALL clear red, green, blue, de and frame_start to 0 and set hsync and vsync to 1 on rst.
REQ-027 SHALL clear the delay pipelines on rst, so no stale de or sync pulse appears after release.
REQ-028 SHALL resume on the first clk after rst deasserts, including after a reset mid-frame, starting a fresh frame at h_cnt=0, v_cnt=0.

Configuration
REQ-029 SHALL, when FB_VGA_TESTPAT_EN is defined, add input tp_en (1 bit); with tp_en=1 the colour outputs show 8 vertical colour bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black, and ignore rdata.
REQ-030 SHALL keep the test-pattern timing and alignment identical to the buffer path; raddr keeps counting either way.
REQ-031 SHALL, when FB_VGA_TESTPAT_EN is not defined, have no tp_en port and no pattern logic.

Verification
REQ-032 SHALL check timing: run 2 frames after reset -> de high for 640 clks per line and 480 lines per frame; line period 800 clks; frame period 420000 clks.
REQ-033 SHALL check syncs: hsync low for 96 clks starting 16 clks after de falls; vsync low for 2 lines (1600 clks) starting 10 lines after the last visible line.
REQ-034 SHALL check addressing: model RAM with rdata=addr[15:0] -> line 0 shows 0,0,1,1,...,319,319; lines 2/3 show 320,320,...; the last pixel shows 76799 (truncated to 16 bits).
REQ-035 SHALL check latency: frame_start coincides with the first de=1 clk and red/green/blue equal the RAM word at address 0; all colours are 0 whenever de=0.
REQ-036 SHALL check mid-frame reset: assert rst at line 200, pixel 100, for 3 clks -> outputs take reset values at once; the next frame_start arrives exactly 3 clks into the first post-reset frame, with raddr restarting at 0.
REQ-037 SHALL check the test pattern, with FB_VGA_TESTPAT_EN defined: tp_en=1 -> pixel 0 is 31/63/31, pixel 80 is 31/63/0, pixel 560 is 0/0/0, independent of rdata.
